// File: rtl/iic_slave.sv
// I2C target (slave) with a local register port; answers DEV_ADDR on a sampled SCL/SDA pair.
// Define IIC_SLAVE_AUTOINC_EN for multi-byte bursts with an auto-incrementing word address.
module iic_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic       wp,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int            CW   = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, WADDR, WADDRACK, WDATA, WDATAACK, RDATA, RDACK, WAIT_STOP
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA through the synchronizer and filter.
  logic [1:0]    raw, sync1, sync2, filt, filt_q;
  logic [CW-1:0] fcnt [2];

  assign raw = {scl, sda};

  // NOTE: the filter counters are a tiny register array, so they are reset
  // like any other flop; large RAM-style arrays would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_q <= '1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FMAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign sda_f    = filt[0];
  assign scl_rise = filt[1] & ~filt_q[1];
  assign scl_fall = ~filt[1] & filt_q[1];
  assign start_c  = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
  assign stop_c   = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

  state_t     state, state_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shift, shift_n, rd_shift, rd_shift_n, addr_n, wdata_n;
  logic [1:0] rd_d;
  logic       phase, phase_n, rw, rw_n, wbyte, wbyte_n;
  logic       sda_oe, oe_n, busy_n, wr_n, rd_n;

  // SDA is only ever pulled low; the async reset of sda_oe releases it at once.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rd_shift  <= '0;
      rd_d      <= '0;
      phase     <= 1'b0;
      rw        <= 1'b0;
      wbyte     <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      shift     <= shift_n;
      rd_shift  <= rd_shift_n;
      rd_d      <= {rd_d[0], reg_rd};
      phase     <= phase_n;
      rw        <= rw_n;
      wbyte     <= wbyte_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_wr    <= wr_n;
      reg_rd    <= rd_n;
    end
  end

  // Ack states use phase: the first SCL fall opens the ACK slot, the second closes it.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n    = state;
    cnt_n      = bit_cnt;
    shift_n    = shift;
    rd_shift_n = rd_shift;
    phase_n    = phase;
    rw_n       = rw;
    wbyte_n    = wbyte;
    oe_n       = sda_oe;
    busy_n     = busy;
    addr_n     = reg_addr;
    wdata_n    = reg_wdata;
    wr_n       = 1'b0;
    rd_n       = 1'b0;
    if (rd_d[1]) rd_shift_n = reg_rdata;

    if (stop_c) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      phase_n = 1'b0;
    end else if (start_c) begin
      state_n = DEVADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      phase_n = 1'b0;
      wbyte_n = 1'b0;
    end else begin
      unique case (state)
        DEVADDR, WADDR, WDATA: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_f};
            cnt_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase_n = 1'b0;
              case (state)
                DEVADDR: begin
                  if (shift[6:0] == DEV_ADDR) begin
                    state_n = DEVACK;
                    busy_n  = 1'b1;
                    rw_n    = sda_f;
                    rd_n    = sda_f;
                  end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                  end
                end
                WADDR: begin
                  addr_n  = {shift[6:0], sda_f};
                  state_n = WADDRACK;
                end
                default: state_n = WDATAACK;
              endcase
            end
          end
        end
        DEVACK, WADDRACK: begin
          if (scl_fall) begin
            if (!phase) begin
              phase_n = 1'b1;
              oe_n    = 1'b1;
            end else begin
              phase_n = 1'b0;
              cnt_n   = '0;
              oe_n    = 1'b0;
              if (state == WADDRACK) begin
                state_n = WDATA;
              end else if (rw) begin
                state_n = RDATA;
                oe_n    = ~rd_shift[7];
              end else begin
                state_n = WADDR;
              end
            end
          end
        end
        WDATAACK: begin
          if (scl_fall) begin
            if (!phase) begin
              if (!wp && (AUTOINC || !wbyte)) begin
                phase_n = 1'b1;
                oe_n    = 1'b1;
                wr_n    = 1'b1;
                wdata_n = shift;
                wbyte_n = 1'b1;
              end else begin
                state_n = WAIT_STOP;
                oe_n    = 1'b0;
              end
            end else begin
              phase_n = 1'b0;
              cnt_n   = '0;
              oe_n    = 1'b0;
              state_n = WDATA;
              if (AUTOINC) addr_n = reg_addr + 8'd1;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_n = RDACK;
              phase_n = 1'b0;
            end
          end else if (scl_fall) begin
            // A fall with no bit yet clocked is the start of an auto-incremented byte.
            if (bit_cnt == 3'd0) begin
              oe_n = ~rd_shift[7];
            end else begin
              rd_shift_n = {rd_shift[6:0], 1'b0};
              oe_n       = ~rd_shift[6];
            end
          end
        end
        RDACK: begin
          if (scl_fall && !phase) begin
            oe_n    = 1'b0;
            phase_n = 1'b1;
          end else if (scl_rise && phase) begin
            if (sda_f || !AUTOINC) begin
              state_n = WAIT_STOP;
            end else begin
              state_n = RDATA;
              cnt_n   = '0;
              addr_n  = reg_addr + 8'd1;
              rd_n    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// Self-checking bench for iic_slave: bit-banged I2C master, transaction-level model,
// and a per-cycle monitor matching register strobes against the model's queues.
module tb_iic_slave;

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [6:0] DEV = 7'h50;
  localparam int         H   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       wp = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;

  pullup (sda_bus);
  assign sda_bus   = m_sda ? 1'bz : 1'b0;
  assign reg_rdata = reg_addr ^ 8'h4A;

  always #5 clk = ~clk;

  iic_slave #(.DEV_ADDR(DEV), .FILT_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda_bus), .wp(wp),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  tx[$];
  bit          silent = 1'b0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr) begin
        check("wr_single_cycle", 32'(prev_wr), 32'(1'b0));
        check("wr_expected", 32'(exp_wr.size() != 0), 32'(1'b1));
        if (exp_wr.size() != 0) check("wr_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
      end
      if (reg_rd) begin
        check("rd_single_cycle", 32'(prev_rd), 32'(1'b0));
        check("rd_expected", 32'(exp_rd.size() != 0), 32'(1'b1));
        if (exp_rd.size() != 0) check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
      end
      if (silent) begin
        check("busy_silent", 32'(busy), 32'(1'b0));
        if (m_sda) check("sda_silent", 32'(sda_bus), 32'(1'b1));
      end
    end
    prev_wr = reg_wr;
    prev_rd = reg_rd;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (!scl) begin
      m_sda = 1'b1; cyc(H); scl = 1'b1; cyc(2*H);
    end
    m_sda = 1'b0; cyc(2*H); scl = 1'b0; cyc(H);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(H); scl = 1'b1; cyc(2*H); m_sda = 1'b1; cyc(2*H);
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    m_sda = b; cyc(H); scl = 1'b1; cyc(H); s = sda_bus; cyc(H); scl = 1'b0; cyc(H);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b, output logic slot);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      b[i] = s;
    end
    i2c_bit(~mack, slot);
  endtask

  // Model: device byte, word address, then data bytes; a NACK silences the rest.
  task automatic run_write(input string tag, input bit send_stop);
    logic ack, exp;
    bit   alive;
    int   nd;
    alive = 1'b1;
    nd    = 0;
    i2c_start();
    for (int i = 0; i < tx.size(); i++) begin
      if (!alive) begin
        exp = 1'b0;
      end else if (i == 0) begin
        exp = (tx[0][7:1] == DEV) && !tx[0][0];
      end else if (i == 1) begin
        exp    = 1'b1;
        m_addr = tx[1];
      end else if (!wp && (AUTOINC || nd == 0)) begin
        exp = 1'b1;
        exp_wr.push_back({m_addr, tx[i]});
        nd++;
        if (AUTOINC) m_addr = m_addr + 8'd1;
      end else begin
        exp = 1'b0;
      end
      alive = alive && exp;
      wr_byte(tx[i], ack);
      check($sformatf("%s_ack%0d", tag, i), 32'(ack), 32'(exp));
    end
    if (send_stop) i2c_stop();
  endtask

  task automatic run_read(input string tag, output logic [7:0] b);
    logic ack, slot;
    i2c_start();
    exp_rd.push_back(m_addr);
    wr_byte({DEV, 1'b1}, ack);
    check({tag, "_devack"}, 32'(ack), 32'(1'b1));
    rd_byte(1'b0, b, slot);
    check({tag, "_data"}, 32'(b), 32'(m_addr ^ 8'h4A));
    check({tag, "_released_after_bit7"}, 32'(slot), 32'(1'b1));
    i2c_stop();
  endtask

  initial begin
    logic [7:0] rb;
    logic       s;

    cyc(5);
    check("rst_sda", 32'(sda_bus), 32'(1'b1));
    check("rst_reg_addr", 32'(reg_addr), 32'(8'h00));
    check("rst_reg_wdata", 32'(reg_wdata), 32'(8'h00));
    check("rst_reg_wr", 32'(reg_wr), 32'(1'b0));
    check("rst_reg_rd", 32'(reg_rd), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    rst_n = 1'b1;
    cyc(10);

    // Single write.
    tx = '{8'hA0, 8'h3C, 8'hA5};
    run_write("wr", 1'b0);
    check("wr_busy_before_stop", 32'(busy), 32'(1'b1));
    i2c_stop();
    cyc(20);
    check("wr_busy_after_stop", 32'(busy), 32'(1'b0));
    check("wr_all_strobes", 32'(exp_wr.size()), 32'(0));
    check("wr_reg_addr", 32'(reg_addr), 32'(m_addr));
    check("wr_reg_addr_lit", 32'(reg_addr), AUTOINC ? 32'h3D : 32'h3C);
    check("wr_reg_wdata_lit", 32'(reg_wdata), 32'h0000_00A5);

    // Address mismatch: target stays off the bus.
    silent = 1'b1;
    tx = '{8'hA2, 8'h3C, 8'hA5};
    run_write("mis", 1'b1);
    cyc(20);
    silent = 1'b0;
    check("mis_busy", 32'(busy), 32'(1'b0));
    check("mis_reg_addr", 32'(reg_addr), 32'(m_addr));

    // Random read: set address, repeated START, read one byte, NACK.
    tx = '{8'hA0, 8'h10};
    run_write("rda", 1'b0);
    run_read("rd", rb);
    cyc(20);
    check("rd_byte_lit", 32'(rb), 32'h0000_005A);
    check("rd_all_strobes", 32'(exp_rd.size()), 32'(0));
    check("rd_busy_after_stop", 32'(busy), 32'(1'b0));

    // Write protect: data NACKed, target then ignores the bus until STOP.
    wp = 1'b1;
    tx = '{8'hA0, 8'h3C, 8'h99, 8'h77};
    run_write("wp", 1'b0);
    check("wp_busy_wait_stop", 32'(busy), 32'(1'b1));
    i2c_stop();
    wp = 1'b0;
    cyc(20);
    check("wp_reg_wdata", 32'(reg_wdata), 32'h0000_00A5);
    check("wp_busy_after_stop", 32'(busy), 32'(1'b0));

    // STOP after four data bits discards the partial byte.
    tx = '{8'hA0, 8'h20};
    run_write("part", 1'b0);
    i2c_bit(1'b1, s); i2c_bit(1'b0, s); i2c_bit(1'b1, s); i2c_bit(1'b1, s);
    i2c_stop();
    cyc(20);
    check("part_reg_addr", 32'(reg_addr), 32'h0000_0020);
    check("part_reg_wdata", 32'(reg_wdata), 32'h0000_00A5);
    check("part_busy", 32'(busy), 32'(1'b0));

    // Reset asserted while the target drives the device-address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(tx[0][i], s);
    m_sda = 1'b1; cyc(H); scl = 1'b1; cyc(H);
    check("devack_driven", 32'(sda_bus), 32'(1'b0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda", 32'(sda_bus), 32'(1'b1));
    check("rst_mid_reg_addr", 32'(reg_addr), 32'(8'h00));
    check("rst_mid_reg_wdata", 32'(reg_wdata), 32'(8'h00));
    check("rst_mid_busy", 32'(busy), 32'(1'b0));
    check("rst_mid_strobes", 32'({reg_wr, reg_rd}), 32'(2'b00));
    m_addr = 8'h00;
    cyc(3);
    rst_n = 1'b1;
    cyc(H); scl = 1'b0; cyc(H);
    i2c_stop();
    cyc(20);

    // Address wrap with auto-increment; single-byte build NACKs the second byte.
    tx = '{8'hA0, 8'hFF, 8'h11, 8'h22};
    run_write("inc", 1'b1);
    cyc(20);
    check("inc_all_strobes", 32'(exp_wr.size()), 32'(0));
    check("inc_reg_addr", 32'(reg_addr), 32'(m_addr));
    check("inc_reg_addr_lit", 32'(reg_addr), AUTOINC ? 32'h01 : 32'hFF);
    check("inc_reg_wdata_lit", 32'(reg_wdata), AUTOINC ? 32'h22 : 32'h11);
    check("inc_busy", 32'(busy), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave.md
# iic_slave

I2C target (slave) controller that answers the team's `iic` master, or any standard-mode I2C master, on the same two-wire bus. It decodes START, device address, word address, data and STOP on a sampled SCL/SDA pair. It exposes a simple local register port (address, write strobe, read strobe, read data) to the owning block and drives SDA open-drain only for ACK slots and read-data bits. It is used wherever a board-level device must be emulated or a register bank must be made I2C-accessible inside the FPGA.

## Interface
- `DEV_ADDR`, 7'h50: 7-bit device address this target answers to.
- `FILT_LEN`, 3: glitch-filter length in `clk` cycles; an input level must be stable this long to be accepted.
- `clk` input 1: global clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `scl` input 1: I2C clock from the master.
- `sda` inout 1: I2C data, open-drain; the block drives only `0` or `z`.
- `wp` input 1: write protect. When 1, write data bytes are NACKed and no write strobe is issued.
- `reg_addr` output 8: current word address.
- `reg_wdata` output 8: last received write data byte.
- `reg_wr` output 1: one-cycle write strobe; `reg_addr` and `reg_wdata` are valid in that cycle.
- `reg_rd` output 1: one-cycle read request for `reg_addr`.
- `reg_rdata` input 8: read data; must be valid 2 cycles after `reg_rd`.
- `busy` output 1: 1 from an addressed-match START until STOP or abort.

## Operation
- Input path: 2-FF synchronizer on `scl` and `sda`, then a `FILT_LEN` stable-count filter on each.
- Edge detection on the filtered signals: SCL rise, SCL fall, START (SDA falls while SCL high), STOP (SDA rises while SCL high).
- Data bits are sampled on SCL rise, MSB first. SDA output changes only on SCL fall. A 3-bit counter counts bits 0..7.
- States:
  - IDLE: waits for START.
  - DEVADDR: after 8 bits, compare [7:1] with `DEV_ADDR`. On mismatch go to IDLE (SDA never driven). On match set `busy` and go to DEVACK.
  - DEVACK: drive SDA low for one SCL pulse.
    - R/W=0 goes to WADDR.
    - R/W=1 pulses `reg_rd` at ACK entry, then goes to RDATA.
  - WADDR: shift 8 bits, load `reg_addr`, go to WADDRACK (ACK), then WDATA.
  - WDATA: shift 8 bits.
    - If `wp`=0: ACK, load `reg_wdata`, pulse `reg_wr` on the SCL fall that starts the ACK.
    - If `wp`=1: NACK and go to WAIT_STOP.
  - RDATA: drive captured `reg_rdata` bits; a 1 bit releases SDA. After bit 7, release SDA and go to RDACK.
  - RDACK: sample the master bit on SCL rise. NACK (1) goes to WAIT_STOP. ACK (0) continues only when auto-increment is compiled in.
  - WAIT_STOP: SDA released; waits for STOP or START.
- START in any state, including a repeated start, goes to DEVADDR with the bit counter cleared. `reg_addr` is kept, so a write-address-then-restart-read sequence reads the addressed word.
- STOP in any state goes to IDLE, releases SDA and clears `busy`. A partial byte is discarded with no strobe.
- `reg_addr` is 8-bit and wraps 0xFF→0x00 when incremented.

## Timing
- Input latency is 2 + `FILT_LEN` cycles.
- Timing requirements: SCL high and low phases must each be ≥ 2×(`FILT_LEN`+4) cycles. SDA setup before SCL rise must be ≥ `FILT_LEN`+3 cycles.
- SDA changes 1 cycle after the detected SCL fall, which gives hold margin over the master.
- `reg_rdata` is captured exactly 2 cycles after `reg_rd`.
- Reset values: `sda` released (z), `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `busy`=0, state IDLE.
- Reset mid-transfer releases SDA immediately (asynchronously).

## Configuration
- `IIC_SLAVE_AUTOINC_EN` defined:
  - After each written byte, or each read byte ACKed by the master, `reg_addr` increments by 1 (wrapping).
  - Writes continue in WDATA.
  - Reads issue a new `reg_rd` on the ACK and return to RDATA.
- `IIC_SLAVE_AUTOINC_EN` undefined:
  - Single byte per transfer.
  - A second write byte is NACKed and no strobe is issued.
  - A master ACK after a read byte goes to WAIT_STOP with SDA released.

## Test plan
- Write: START, 0xA0, 0x3C, 0xA5, STOP with `wp`=0 → three ACKs (SDA low at each 9th SCL high); exactly one `reg_wr` with `reg_addr`=0x3C and `reg_wdata`=0xA5; `busy` falls after STOP.
- Address mismatch: START, 0xA2, … → SDA never driven low, no strobes, `busy` stays 0.
- Random read: write address 0x10, repeated START, 0xA1, `reg_rdata`=0x5A, master NACK, STOP → one `reg_rd` with `reg_addr`=0x10; SDA bits 0,1,0,1,1,0,1,0; SDA released after bit 7.
- Write protect: `wp`=1, write 0x3C/0xA5 → address bytes ACKed, data byte NACKed, no `reg_wr`, state WAIT_STOP.
- STOP after 4 data bits, then `rst_n` low during a DEVACK → no `reg_wr`; SDA released within the reset assertion; all outputs return to reset values.
- With `IIC_SLAVE_AUTOINC_EN`: write 0xFF then 0x11, 0x22 → `reg_wr` at 0xFF/0x11 then 0x00/0x22; without the macro the second byte is NACKed.
